// File: rtl/piso_tx_pkg.sv
// ----------------------------------------------------------------------------
// piso_tx_pkg
// Shared definitions for the PISO transmit sequencer.
//   - state_e       : controller FSM state encoding
//   - DEF_WIDTH     : default data word width
//   - DEF_GAP_CYCLES: default idle cycles between frames
//   - cnt_width()   : counter width able to hold 0..n, never less than 1 bit
// ----------------------------------------------------------------------------
package piso_tx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      GAP    = 2'd3
   } state_e;

   localparam int DEF_WIDTH      = 10;
   localparam int DEF_GAP_CYCLES = 1;

   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// ----------------------------------------------------------------------------
// piso_shift_reg
// WIDTH-bit parallel-load, shift-left register. The serial output is the MSB.
// Load takes priority over shift when both are requested in the same cycle.
//
// Ports:
//   i_clk     clock, rising edge
//   i_resetn  synchronous active-low reset, clears the register
//   i_load    load i_data on this edge
//   i_shift   shift left by one, filling bit 0 from i_sin
//   i_sin     serial fill bit
//   i_data    parallel load word
//   o_msb     register bit WIDTH-1
// ----------------------------------------------------------------------------
module piso_shift_reg
   import piso_tx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_resetn,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic             i_sin,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_msb
);

   logic [WIDTH-1:0] r_sreg;

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_sreg <= '0;
      end else if (i_load) begin
         r_sreg <= i_data;
      end else if (i_shift) begin
         r_sreg <= {r_sreg[WIDTH-2:0], i_sin};
      end
   end

   assign o_msb = r_sreg[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// ----------------------------------------------------------------------------
// piso_tx_ctrl
// Accepts parallel words over valid/ready and serialises them MSB-first as
// framed bursts on o_sout, separated by GAP_CYCLES idle cycles. Owns the only
// load path into the attached shift register.
//
// Optional feature: define PISO_TX_CTRL_PARITY_EN to append one even-parity
// bit (XOR of the accepted word) after DATA[0]. In that build DONE moves to
// the parity cycle and READY stays low during it.
//
// Ports:
//   i_clk     clock, rising edge
//   i_resetn  synchronous active-low reset; also gates o_ready directly
//   i_data    parallel word, sampled only on handshake
//   i_valid   upstream word available
//   o_ready   word accepted at this edge when i_valid is also high
//   o_sout    serial data bit
//   o_frame   high while o_sout carries a frame bit
//   o_done    one-cycle pulse on the last frame bit
//
// state  | meaning
// IDLE   | waiting for a word, READY high
// SHIFT  | data bits on o_sout, MSB first
// PARITY | even-parity bit on o_sout (parity build only)
// GAP    | inter-frame idle, GAP_CYCLES long
// ----------------------------------------------------------------------------
module piso_tx_ctrl
   import piso_tx_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic             i_clk,
   input  logic             i_resetn,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_sout,
   output logic             o_frame,
   output logic             o_done
);

   localparam int CW = cnt_width(WIDTH);
   localparam int GW = cnt_width(GAP_CYCLES);

   localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
   // Gap counter counts down from GAP_CYCLES-1 to 0; unused when GAP_CYCLES=0.
   localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
`ifndef PISO_TX_CTRL_PARITY_EN
   localparam logic [CW-1:0] BIT_PEN  = CW'(WIDTH - 2);
`endif

   state_e        r_state;
   logic [CW-1:0] r_bit_cnt;
   logic [GW-1:0] r_gap_cnt;
   logic          r_frame;
   logic          r_done;
`ifdef PISO_TX_CTRL_PARITY_EN
   logic          r_parity;
`endif

   logic w_last_bit;
   logic w_ready;
   logic w_hs;
   logic w_shift;
   logic w_sr_msb;
   logic w_sout;

   assign w_last_bit = (r_state == SHIFT) && (r_bit_cnt == BIT_LAST);

   // With no gap and no parity cycle, the last data bit doubles as an accept
   // slot so consecutive frames run back to back.
`ifdef PISO_TX_CTRL_PARITY_EN
   assign w_ready = i_resetn && (r_state == IDLE);
`else
   assign w_ready = i_resetn &&
                    ((r_state == IDLE) || ((GAP_CYCLES == 0) && w_last_bit));
`endif

   assign w_hs    = i_valid && w_ready;
   assign w_shift = (r_state == SHIFT);

   piso_shift_reg #(
      .WIDTH (WIDTH)
   ) u_shift_reg (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .i_load   (w_hs),
      .i_shift  (w_shift),
      .i_sin    (1'b0),
      .i_data   (i_data),
      .o_msb    (w_sr_msb)
   );

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_frame   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_frame <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_hs) begin
                  r_state   <= SHIFT;
                  r_bit_cnt <= '0;
                  r_frame   <= 1'b1;
               end
            end

            SHIFT: begin
               if (w_last_bit) begin
`ifdef PISO_TX_CTRL_PARITY_EN
                  r_state <= PARITY;
                  r_frame <= 1'b1;
                  r_done  <= 1'b1;
`else
                  if (GAP_CYCLES > 0) begin
                     r_state   <= GAP;
                     r_gap_cnt <= GAP_LOAD;
                  end else if (w_hs) begin
                     r_bit_cnt <= '0;
                     r_frame   <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                  end
`endif
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  r_frame   <= 1'b1;
`ifndef PISO_TX_CTRL_PARITY_EN
                  r_done    <= (r_bit_cnt == BIT_PEN);
`endif
               end
            end

            PARITY: begin
               r_state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
               r_gap_cnt <= GAP_LOAD;
            end

            GAP: begin
               if (r_gap_cnt == '0) begin
                  r_state <= IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 1'b1;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef PISO_TX_CTRL_PARITY_EN
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_parity <= 1'b0;
      end else if (w_hs) begin
         r_parity <= ^i_data;
      end
   end
`endif

   always_comb begin
      w_sout = 1'b0;
      if (r_state == SHIFT) begin
         w_sout = w_sr_msb;
      end
`ifdef PISO_TX_CTRL_PARITY_EN
      else if (r_state == PARITY) begin
         w_sout = r_parity;
      end
`endif
   end

   assign o_ready = w_ready;
   assign o_sout  = w_sout;
   assign o_frame = r_frame;
   assign o_done  = r_done;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_piso_tx_ctrl
// Two instances share clock and reset: u_dut1 (GAP_CYCLES=1) and u_dut0
// (GAP_CYCLES=0), both WIDTH=10. Expectations follow the
// PISO_TX_CTRL_PARITY_EN build setting.
// ----------------------------------------------------------------------------
module tb_piso_tx_ctrl;

`ifdef PISO_TX_CTRL_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FL = 10 + PAR;

   logic       clk;
   logic       rstn;
   logic [9:0] data1, data0;
   logic       valid1, valid0;
   logic       ready1, sout1, frame1, done1;
   logic       ready0, sout0, frame0, done0;

   int n_checks = 0;
   int n_fail   = 0;

   piso_tx_ctrl #(.WIDTH(10), .GAP_CYCLES(1)) u_dut1 (
      .i_clk    (clk),
      .i_resetn (rstn),
      .i_data   (data1),
      .i_valid  (valid1),
      .o_ready  (ready1),
      .o_sout   (sout1),
      .o_frame  (frame1),
      .o_done   (done1)
   );

   piso_tx_ctrl #(.WIDTH(10), .GAP_CYCLES(0)) u_dut0 (
      .i_clk    (clk),
      .i_resetn (rstn),
      .i_data   (data0),
      .i_valid  (valid0),
      .o_ready  (ready0),
      .o_sout   (sout0),
      .o_frame  (frame0),
      .o_done   (done0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rstn;
      logic       valid;
      logic [9:0] data;
      logic       e_ready;
      logic       e_frame;
      logic       e_sout;
      logic       e_done;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends one word on u_dut1 from IDLE and checks the full frame plus gap.
   task automatic send1(input logic [9:0] w, input bit toggle, input string tag);
      logic exp_bit;
      valid1 = 1'b1;
      data1  = w;
      #1;
      chk($sformatf("%s accept_ready", tag), ready1, 1'b1);
      step();
      for (int i = 0; i < FL; i++) begin
         if (toggle) begin
            valid1 = 1'($urandom);
            data1  = 10'($urandom);
         end else begin
            valid1 = 1'b0;
         end
         #1;
         exp_bit = (i < 10) ? w[9-i] : ^w;
         chk($sformatf("%s sout[%0d]", tag, i), sout1, exp_bit);
         chk($sformatf("%s frame[%0d]", tag, i), frame1, 1'b1);
         chk($sformatf("%s done[%0d]", tag, i), done1, (i == FL - 1));
         chk($sformatf("%s ready[%0d]", tag, i), ready1, 1'b0);
         step();
      end
      valid1 = 1'b0;
      #1;
      chk($sformatf("%s gap_frame", tag), frame1, 1'b0);
      chk($sformatf("%s gap_ready", tag), ready1, 1'b0);
      chk($sformatf("%s gap_sout", tag), sout1, 1'b0);
      step();
      chk($sformatf("%s idle_ready", tag), ready1, 1'b1);
      chk($sformatf("%s idle_frame", tag), frame1, 1'b0);
   endtask

   initial begin
      // reset: two more reset cycles after the first edge
      tbl.push_back('{1'b0, 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0});
      // released, idle, no frame without a handshake
      tbl.push_back('{1'b1, 1'b0, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0});
      // handshake 10'h2B5
      tbl.push_back('{1'b1, 1'b1, 10'h2B5, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0});
`ifdef PISO_TX_CTRL_PARITY_EN
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b1});
`else
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b1});
`endif
      // gap cycle, then ready again
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0});

      rstn   = 1'b0;
      valid1 = 1'b1;
      data1  = 10'h3FF;
      valid0 = 1'b0;
      data0  = 10'h000;
      step();

      for (int v = 0; v < tbl.size(); v++) begin
         rstn   = tbl[v].rstn;
         valid1 = tbl[v].valid;
         data1  = tbl[v].data;
         #1;
         chk($sformatf("vec%0d ready", v), ready1, tbl[v].e_ready);
         chk($sformatf("vec%0d frame", v), frame1, tbl[v].e_frame);
         chk($sformatf("vec%0d sout", v), sout1, tbl[v].e_sout);
         chk($sformatf("vec%0d done", v), done1, tbl[v].e_done);
         step();
      end
      valid1 = 1'b0;

      // back-to-back on the zero-gap instance, VALID held throughout
      valid0 = 1'b1;
      data0  = 10'h3FF;
      #1;
      chk("b2b accept_ready", ready0, 1'b1);
      step();
      data0 = 10'h000;
`ifdef PISO_TX_CTRL_PARITY_EN
      for (int i = 0; i < 23; i++) begin
         if (i == 22) valid0 = 1'b0;
         #1;
         if (i == 11) begin
            chk("b2b par idle_frame", frame0, 1'b0);
            chk("b2b par idle_ready", ready0, 1'b1);
         end else begin
            chk($sformatf("b2b frame[%0d]", i), frame0, 1'b1);
            chk($sformatf("b2b sout[%0d]", i), sout0, (i < 10));
            chk($sformatf("b2b done[%0d]", i), done0, (i == 10 || i == 22));
            chk($sformatf("b2b ready[%0d]", i), ready0, 1'b0);
         end
         step();
      end
`else
      for (int i = 0; i < 20; i++) begin
         if (i == 19) valid0 = 1'b0;
         #1;
         chk($sformatf("b2b frame[%0d]", i), frame0, 1'b1);
         chk($sformatf("b2b sout[%0d]", i), sout0, (i < 10));
         chk($sformatf("b2b done[%0d]", i), done0, (i == 9 || i == 19));
         chk($sformatf("b2b ready[%0d]", i), ready0, (i == 9 || i == 19));
         step();
      end
`endif
      chk("b2b end_frame", frame0, 1'b0);
      chk("b2b end_ready", ready0, 1'b1);
      chk("b2b end_done", done0, 1'b0);

      // stall immunity: inputs toggled during the frame
      send1(10'h2B5, 1'b1, "stall");

      // reset mid-frame after four bits
      valid1 = 1'b1;
      data1  = 10'h2B5;
      #1;
      chk("rst accept_ready", ready1, 1'b1);
      step();
      valid1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("rst pre sout[%0d]", i), sout1, (i == 0 || i == 2));
         chk($sformatf("rst pre frame[%0d]", i), frame1, 1'b1);
         step();
      end
      rstn = 1'b0;
      #1;
      chk("rst ready_gated", ready1, 1'b0);
      chk("rst done_low", done1, 1'b0);
      step();
      rstn = 1'b1;
      #1;
      chk("rst post frame", frame1, 1'b0);
      chk("rst post done", done1, 1'b0);
      chk("rst post sout", sout1, 1'b0);
      chk("rst post ready", ready1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rst quiet frame[%0d]", i), frame1, 1'b0);
         chk($sformatf("rst quiet done[%0d]", i), done1, 1'b0);
      end

      // clean word after the aborted frame: nine 0s then a 1
      send1(10'h001, 1'b0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
